split_3_gen: RTL and testbench
==============================

SPLIT_3_GEN -- requirements
Module: split_3_gen

Interface
REQ-001 Parameter WIDTH, default 32, sets the candidate and seed width in bits.
REQ-002 Parameter FORBID, default 32'h6839A06F, is the single value the output shall never take.
REQ-003 Parameter MAX_RETRY, default 4, is the number of rejected candidates allowed per request before failure.
REQ-004 Port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port seed_load, input, 1 bit: load seed into the LFSR.
REQ-007 Port seed, input, WIDTH bits: seed value.
REQ-008 Port req, input, 1 bit: request one satisfying value.
REQ-009 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 Port out_valid, output, 1 bit: result is valid.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port out_value, output, WIDTH bits: generated value satisfying (value != FORBID).
REQ-013 Port out_fail, output, 1 bit: qualified by out_valid; high means retries were exhausted and out_value is invalid.
REQ-014 Port reject_cnt, output, 16 bits: saturating count of rejected candidates since reset.

Function
REQ-015 States shall be IDLE, CHECK and HOLD, encoded as an enum.
REQ-016 The LFSR shall be WIDTH-bit Galois, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003), shifting right and XORing the mask when the shifted-out bit is 1.
REQ-017 In IDLE, seed_load shall set the LFSR to seed, or to 1 if seed is 0, and shall take priority over req in the same cycle.
REQ-018 seed_load outside IDLE shall be ignored.
REQ-019 In IDLE with req=1 and seed_load=0, the FSM shall go to CHECK and clear the retry counter.
REQ-020 In CHECK, the candidate shall be the current LFSR state, not a stepped value.
REQ-021 In CHECK, if candidate != FORBID, the FSM shall capture it into out_value, set out_fail=0, go to HOLD, and leave the LFSR unstepped.
REQ-022 In CHECK, if candidate == FORBID, the FSM shall step the LFSR, increment reject_cnt (saturating at 16'hFFFF), and increment the retry counter.
REQ-023 When a rejection makes the retry counter equal MAX_RETRY, the FSM shall go to HOLD with out_fail=1; otherwise it shall stay in CHECK.
REQ-024 In HOLD, out_valid=1 and out_value/out_fail shall be held stable until out_ready=1.
REQ-025 On the HOLD handshake (out_valid & out_ready), the LFSR shall step once and the FSM shall return to IDLE.
REQ-026 The handshake shall complete in the same cycle out_ready is seen; out_ready outside HOLD has no effect.
REQ-027 req outside IDLE shall be ignored; requests are not queued.
REQ-028 Latency: req sampled at edge t gives CHECK at t+1; out_valid shall rise after edge t+2 for a zero-reject request.
REQ-029 Each rejection shall add exactly one cycle of latency.
REQ-030 The LFSR never produces 0, so output 0 is unreachable; this is acceptable.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, LFSR=1, out_valid=0, out_fail=0, out_value=0, reject_cnt=0, retry counter=0, busy=0.
REQ-032 Reset mid-request shall abort the request with no output handshake.
REQ-033 rst shall override seed_load and req in the same cycle.

Structure
REQ-034 Package split_3_gen_pkg shall hold the state enum, the tap-mask constant, the default FORBID constant, and a pure function lfsr_step.
REQ-035 The LFSR shall be one sub-module, split_3_lfsr, with ports clk, rst, load, load_val, step, and state.
REQ-036 The FSM, the predicate compare and the counters shall reside in split_3_gen.

Verification
REQ-037 Reset, then req without seeding -> out_valid after 2 edges, out_value=32'h00000001, out_fail=0, reject_cnt=0.
REQ-038 seed_load with seed=0 -> LFSR=1; req -> out_value=32'h00000001.
REQ-039 seed_load with seed=32'h6839A06F, then req -> one reject, out_value=lfsr_step(32'h6839A06F), out_valid after 3 edges, reject_cnt=1.
REQ-040 MAX_RETRY=1 with seed=32'h6839A06F, then req -> out_valid=1 and out_fail=1 after 2 edges, reject_cnt=1.
REQ-041 Hold out_ready=0 for 5 cycles while pulsing req and seed_load -> out_value stable, no new request, LFSR unchanged; out_ready=1 -> IDLE next edge, LFSR stepped.
REQ-042 Assert rst while in CHECK or HOLD -> all outputs at reset values next cycle; a subsequent req yields out_value=32'h00000001.

Source files
------------

// File: rtl/split_3_gen_pkg.sv
// Shared types, constants and the LFSR next-state function for the split_3_gen
// constrained random-value generator.
package split_3_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] TAP_MASK       = 32'h8020_0003;
  localparam logic [31:0] FORBID_DEFAULT = 32'h6839_A06F;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAP_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/split_3_lfsr.sv
// Galois LFSR holding the candidate value; load wins over step, and a zero
// load is replaced by 1 so the register never locks up at all-zeros.
module split_3_lfsr
  import split_3_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next_val;

  // The polynomial is degree 32; WIDTH is expected to stay at 32.
  assign next_val = WIDTH'(lfsr_step(32'(state)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WIDTH'(1);
    end else if (load) begin
      state <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      state <= next_val;
    end
  end

endmodule

// File: rtl/split_3_gen.sv
// Produces one LFSR value != FORBID per request, retrying up to MAX_RETRY
// times, and presents it on a valid/ready handshake.
module split_3_gen
  import split_3_gen_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FORBID    = WIDTH'(FORBID_DEFAULT),
  parameter int               MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_fail,
  output logic [15:0]      reject_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t           state_q, state_n;
  logic [RW-1:0]    retry_q, retry_n;
  logic [WIDTH-1:0] cand, value_n;
  logic             fail_n, lfsr_load, lfsr_adv, hit;
  logic [15:0]      reject_n;

  split_3_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_adv),
    .state    (cand)
  );

  assign hit       = (cand == FORBID);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n   = state_q;
    retry_n   = retry_q;
    value_n   = out_value;
    fail_n    = out_fail;
    reject_n  = reject_cnt;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (req) begin
          state_n = CHECK;
          retry_n = '0;
        end
      end
      CHECK: begin
        if (!hit) begin
          value_n = cand;
          fail_n  = 1'b0;
          state_n = HOLD;
        end else begin
          lfsr_adv = 1'b1;
          retry_n  = retry_q + RW'(1);
          if (reject_cnt != 16'hFFFF) reject_n = reject_cnt + 16'd1;
          if (retry_n == RW'(MAX_RETRY)) begin
            fail_n  = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // Stepping on acceptance makes the next request see a fresh value.
        if (out_ready) begin
          lfsr_adv = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      out_value  <= '0;
      out_fail   <= 1'b0;
      reject_cnt <= '0;
    end else begin
      state_q    <= state_n;
      retry_q    <= retry_n;
      out_value  <= value_n;
      out_fail   <= fail_n;
      reject_cnt <= reject_n;
    end
  end

endmodule

// File: tb/tb_split_3_gen.sv
// Self-checking bench for split_3_gen: directed corner cases plus randomized
// seeds, compared against a request-level reference model.
module tb_split_3_gen;

  localparam logic [31:0] FORBID    = 32'h6839_A06F;
  localparam int          MAX_RETRY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, seed_load = 1'b0, req = 1'b0, out_ready = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, out_valid, out_fail;
  logic [31:0] out_value;
  logic [15:0] reject_cnt;

  logic        r1_seed_load = 1'b0, r1_req = 1'b0, r1_out_ready = 1'b0;
  logic [31:0] r1_seed = '0;
  logic        r1_busy, r1_out_valid, r1_out_fail;
  logic [31:0] r1_out_value;
  logic [15:0] r1_reject_cnt;

  split_3_gen dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_fail(out_fail), .reject_cnt(reject_cnt)
  );

  split_3_gen #(.MAX_RETRY(1)) dut1 (
    .clk(clk), .rst(rst), .seed_load(r1_seed_load), .seed(r1_seed), .req(r1_req),
    .busy(r1_busy), .out_valid(r1_out_valid), .out_ready(r1_out_ready),
    .out_value(r1_out_value), .out_fail(r1_out_fail), .reject_cnt(r1_reject_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_lfsr;
  int          m_rej;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Right-shifting Galois step written as plain arithmetic.
  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return (x / 2) ^ ((x % 2 == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed_load = 1'b1;
    seed      = v;
    tick();
    seed_load = 1'b0;
    m_lfsr    = (v == 0) ? 32'd1 : v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":busy"},       busy,       0);
    check({tag, ":out_valid"},  out_valid,  0);
    check({tag, ":out_fail"},   out_fail,   0);
    check({tag, ":out_value"},  out_value,  0);
    check({tag, ":reject_cnt"}, reject_cnt, 0);
  endtask

  // Issues one request, predicts its outcome from the model LFSR, holds the
  // result for hold_cycles (optionally with req/seed_load noise), then accepts.
  task automatic run_req(input string tag, input int hold_cycles, input bit noise);
    logic [31:0] cand;
    int          rej, exp_edges, edges;
    bit          fail;
    cand = m_lfsr;
    rej  = 0;
    fail = 1'b0;
    while (cand == FORBID && !fail) begin
      rej++;
      if (m_rej < 65535) m_rej++;
      cand = ref_step(cand);
      if (rej == MAX_RETRY) fail = 1'b1;
    end
    exp_edges = fail ? 1 + rej : 2 + rej;

    req   = 1'b1;
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
      req = 1'b0;
    end
    req = 1'b0;
    check({tag, ":latency"},    edges,      exp_edges);
    check({tag, ":out_fail"},   out_fail,   fail);
    if (!fail) check({tag, ":out_value"}, out_value, cand);
    check({tag, ":reject_cnt"}, reject_cnt, m_rej);
    m_lfsr = cand;

    for (int i = 0; i < hold_cycles; i++) begin
      if (noise) begin
        req       = 1'b1;
        seed_load = 1'b1;
        seed      = $urandom;
      end
      tick();
      check({tag, ":hold_valid"}, out_valid, 1);
      check({tag, ":hold_fail"},  out_fail,  fail);
      if (!fail) check({tag, ":hold_value"}, out_value, cand);
    end
    req       = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ":back_idle"}, {busy, out_valid}, 0);
    m_lfsr = ref_step(m_lfsr);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    m_lfsr = 32'd1;
    m_rej  = 0;
    check_reset_state("reset");
    check("reset:r1_busy", {r1_busy, r1_out_valid, r1_reject_cnt}, 0);

    run_req("no_seed", 0, 1'b0);
    load_seed(32'd0);
    run_req("seed_zero", 0, 1'b0);
    load_seed(FORBID);
    run_req("one_reject", 0, 1'b0);
    run_req("hold_noise", 5, 1'b1);
    run_req("chained", 1, 1'b0);

    // seed_load beats req when both arrive in IDLE.
    seed_load = 1'b1;
    req       = 1'b1;
    seed      = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    req       = 1'b0;
    m_lfsr    = 32'hDEAD_BEEF;
    check("priority:busy", busy, 0);
    run_req("priority", 0, 1'b0);

    // MAX_RETRY=1 instance: a single rejection exhausts the budget.
    r1_seed      = FORBID;
    r1_seed_load = 1'b1;
    tick();
    r1_seed_load = 1'b0;
    r1_req       = 1'b1;
    tick();
    r1_req = 1'b0;
    check("r1:check_busy",  {r1_busy, r1_out_valid}, 2'b10);
    tick();
    check("r1:out_valid",   r1_out_valid,  1);
    check("r1:out_fail",    r1_out_fail,   1);
    check("r1:reject_cnt",  r1_reject_cnt, 1);
    r1_out_ready = 1'b1;
    tick();
    r1_out_ready = 1'b0;
    check("r1:back_idle",   r1_busy,       0);

    // Reset while in CHECK.
    load_seed(FORBID);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rst_check:busy", busy, 1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    m_lfsr = 32'd1;
    m_rej  = 0;
    check_reset_state("rst_check");
    run_req("after_rst_check", 0, 1'b0);

    // Reset while in HOLD.
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("rst_hold:valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    m_lfsr = 32'd1;
    m_rej  = 0;
    check_reset_state("rst_hold");
    run_req("after_rst_hold", 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0:       load_seed(FORBID);
        1:       load_seed(32'd0);
        2:       load_seed($urandom);
        default: ;
      endcase
      run_req("random", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
